// File: rtl/s_id_ex_pipe.sv
// ID/EX pipeline register with valid/ready handshake, flush, and a saturating stall counter.
// Optional skid entry selected by S_ID_EX_SKID_EN (registered in_ready, two-deep FIFO).
module s_id_ex_pipe #(
  parameter  int DATA_W = 32,
  parameter  int REG_W  = 5,
  parameter  int CTL_W  = 13,
  localparam int PAY_W  = 4*DATA_W + 2*REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTL_W-1:0] ctl_in,
  input  logic [PAY_W-1:0] pay_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTL_W-1:0] ctl_out,
  output logic [PAY_W-1:0] pay_out,
  output logic [15:0]      stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e           state_q;
  logic             main_valid_q;
  logic [CTL_W-1:0] main_ctl_q;
  logic [PAY_W-1:0] main_pay_q;
  logic [15:0]      stall_cnt_q;
  logic [15:0]      stall_cnt_d;
  logic             accept;

`ifdef S_ID_EX_SKID_EN
  logic             skid_valid_q;
  logic [CTL_W-1:0] skid_ctl_q;
  logic [PAY_W-1:0] skid_pay_q;

  // Registered ready: upstream never sees a combinational path from out_ready.
  assign in_ready = !skid_valid_q;
`else
  assign in_ready = out_ready || !main_valid_q;
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = main_valid_q;
  assign ctl_out   = main_ctl_q;
  assign pay_out   = main_pay_q;
  assign stall_cnt = stall_cnt_q;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && !flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the payload flops are reset too, because pay_out must read zero after reset.
      state_q      <= ST_EMPTY;
      main_valid_q <= 1'b0;
      main_ctl_q   <= '0;
      main_pay_q   <= '0;
      stall_cnt_q  <= '0;
`ifdef S_ID_EX_SKID_EN
      skid_valid_q <= 1'b0;
      skid_ctl_q   <= '0;
      skid_pay_q   <= '0;
`endif
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (flush) begin
        // Squash keeps the payload; only valid and control go to the bubble value.
        state_q      <= ST_EMPTY;
        main_valid_q <= 1'b0;
        main_ctl_q   <= '0;
`ifdef S_ID_EX_SKID_EN
        skid_valid_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              state_q      <= ST_FULL;
              main_valid_q <= 1'b1;
              main_ctl_q   <= ctl_in;
              main_pay_q   <= pay_in;
            end
          end
          ST_FULL: begin
            if (out_ready) begin
              if (accept) begin
                main_ctl_q <= ctl_in;
                main_pay_q <= pay_in;
              end else begin
                state_q      <= ST_EMPTY;
                main_valid_q <= 1'b0;
                main_ctl_q   <= '0;
              end
            end
`ifdef S_ID_EX_SKID_EN
            else if (accept) begin
              state_q      <= ST_SKID;
              skid_valid_q <= 1'b1;
              skid_ctl_q   <= ctl_in;
              skid_pay_q   <= pay_in;
            end
`endif
          end
`ifdef S_ID_EX_SKID_EN
          ST_SKID: begin
            if (out_ready) begin
              state_q      <= ST_FULL;
              main_ctl_q   <= skid_ctl_q;
              main_pay_q   <= skid_pay_q;
              skid_valid_q <= 1'b0;
            end
          end
`endif
          default: begin
            state_q      <= ST_EMPTY;
            main_valid_q <= 1'b0;
            main_ctl_q   <= '0;
          end
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  a_bubble_ctl_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid |-> (ctl_out == '0));

  a_hold_under_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(pay_out) && $stable(ctl_out)));
`endif

endmodule

// File: tb/tb_s_id_ex_pipe.sv
// Self-checking bench for s_id_ex_pipe: directed table, hand sequences, and random traffic
// compared against a queue-based reference model.
module tb_s_id_ex_pipe;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTL_W  = 13;
  localparam int PAY_W  = 4*DATA_W + 2*REG_W;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [CTL_W-1:0] ctl_in;
  logic [PAY_W-1:0] pay_in;
  logic             out_valid;
  logic             out_ready;
  logic [CTL_W-1:0] ctl_out;
  logic [PAY_W-1:0] pay_out;
  logic [15:0]      stall_cnt;

  s_id_ex_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .CTL_W(CTL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctl_in    (ctl_in),
    .pay_in    (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ctl_out   (ctl_out),
    .pay_out   (pay_out),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CTL_W-1:0] ctl;
    logic [PAY_W-1:0] pay;
  } instr_t;

  typedef struct {
    string            name;
    bit               r;
    bit               f;
    bit               iv;
    logic [CTL_W-1:0] c;
    bit               ordy;
    bit               e_ov;
    logic [CTL_W-1:0] e_ctl;
    logic [15:0]      e_stall;
  } vec_t;

  // Reference model: instructions held by the stage, oldest first.
  instr_t           mq[$];
  int unsigned      m_stall;
  logic [PAY_W-1:0] m_pay;
  bit               m_known;

  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit exp_in_ready(input bit ordy);
`ifdef S_ID_EX_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || ordy;
`endif
  endfunction

  function automatic logic [PAY_W-1:0] mk_pay(input logic [31:0] npc, input logic [CTL_W-1:0] c);
    return {npc, ~npc, {19'd0, c}, {c, 19'h5A5A5}, c[4:0], c[9:5]};
  endfunction

  function automatic logic [PAY_W-1:0] rnd_pay();
    logic [9:0] regs;
    regs = 10'($urandom);
    return {$urandom, $urandom, $urandom, $urandom, regs};
  endfunction

  // One clock cycle: drive at negedge, check ready before the edge, check outputs after it.
  task automatic step(input bit r, input bit f, input bit iv, input logic [CTL_W-1:0] c,
                      input logic [PAY_W-1:0] p, input bit ordy);
    bit acc;
    bit eir;
    rst_n     = r;
    flush     = f;
    in_valid  = iv;
    ctl_in    = c;
    pay_in    = p;
    out_ready = ordy;
    #1;
    eir = exp_in_ready(ordy);
    if (m_known) check("in_ready", 160'(in_ready), 160'(eir));
    acc = iv && eir;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_stall = 0;
      m_pay   = '0;
      m_known = 1'b1;
    end else if (f) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && !ordy && m_stall < 65535) m_stall++;
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (acc) mq.push_back('{ctl: c, pay: p});
    end
    if (mq.size() > 0) m_pay = mq[0].pay;
    #1;
    if (m_known) begin
      check("out_valid", 160'(out_valid), 160'(mq.size() > 0));
      check("ctl_out",   160'(ctl_out),   160'((mq.size() > 0) ? mq[0].ctl : '0));
      check("pay_out",   160'(pay_out),   160'(m_pay));
      check("stall_cnt", 160'(stall_cnt), 160'(m_stall));
    end
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    n_vec   = 0;
    n_err   = 0;
    m_stall = 0;
    m_pay   = '0;
    m_known = 1'b0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; ctl_in = '0; pay_in = '0; out_ready = 1'b0;

    //            name       r  f  iv ctl       rdy  ov ctl       stall
    vt[0] = '{"rst0",      0, 0, 1, 13'h1ABC, 1,   0, 13'h0000, 16'd0};
    vt[1] = '{"rst1",      0, 0, 1, 13'h1ABC, 1,   0, 13'h0000, 16'd0};
    vt[2] = '{"stream0",   1, 0, 1, 13'h1ABC, 1,   1, 13'h1ABC, 16'd0};
    vt[3] = '{"stream1",   1, 0, 1, 13'h0123, 1,   1, 13'h0123, 16'd0};
    vt[4] = '{"stream2",   1, 0, 1, 13'h1FFF, 1,   1, 13'h1FFF, 16'd0};
    vt[5] = '{"drain",     1, 0, 0, 13'h0000, 1,   0, 13'h0000, 16'd0};
    vt[6] = '{"fill",      1, 0, 1, 13'h1FFF, 0,   1, 13'h1FFF, 16'd0};
    vt[7] = '{"flush",     1, 1, 1, 13'h0555, 0,   0, 13'h0000, 16'd0};
    vt[8] = '{"postflush", 1, 0, 0, 13'h0000, 1,   0, 13'h0000, 16'd0};

    @(negedge clk);
    foreach (vt[i]) begin
      step(vt[i].r, vt[i].f, vt[i].iv, vt[i].c, mk_pay(32'h100 + 32'(i), vt[i].c), vt[i].ordy);
      check($sformatf("%s.ov", vt[i].name),    160'(out_valid), 160'(vt[i].e_ov));
      check($sformatf("%s.ctl", vt[i].name),   160'(ctl_out),   160'(vt[i].e_ctl));
      check($sformatf("%s.stall", vt[i].name), 160'(stall_cnt), 160'(vt[i].e_stall));
    end
    check("reset.pay_zero_seen_then_flush_keeps", 160'(pay_out), 160'(mk_pay(32'h106, 13'h1FFF)));

    // Backpressure: hold an instruction for five stalled cycles, then stream the next one.
    step(1, 0, 1, 13'h0040, mk_pay(32'h0000_0040, 13'h0040), 1);
    for (int k = 0; k < 5; k++) step(1, 0, 0, '0, '0, 0);
    check("bp.stall5", 160'(stall_cnt), 160'(16'd5));
    check("bp.npc", 160'(pay_out[PAY_W-1 -: 32]), 160'(32'h0000_0040));
    step(1, 0, 1, 13'h0777, mk_pay(32'h0000_0044, 13'h0777), 1);
    check("bp.next", 160'(ctl_out), 160'(13'h0777));
    step(1, 0, 0, '0, '0, 1);
    check("bp.empty", 160'(out_valid), 160'(1'b0));

`ifdef S_ID_EX_SKID_EN
    // Skid: second instruction parks while EX stalls, then both leave in order.
    step(1, 0, 1, 13'h0111, mk_pay(32'h200, 13'h0111), 1);
    step(1, 0, 1, 13'h0AAA, mk_pay(32'h204, 13'h0AAA), 0);
    check("skid.ready_low", 160'(in_ready), 160'(1'b0));
    check("skid.orig_held", 160'(ctl_out), 160'(13'h0111));
    step(1, 0, 0, '0, '0, 1);
    check("skid.second", 160'(ctl_out), 160'(13'h0AAA));
    check("skid.ready_back", 160'(in_ready), 160'(1'b1));
    step(1, 0, 0, '0, '0, 1);
`endif

    // Reset in the middle of a transfer drops both the held and the incoming instruction.
    step(1, 0, 1, 13'h0321, mk_pay(32'h300, 13'h0321), 1);
    step(0, 0, 1, 13'h0654, mk_pay(32'h304, 13'h0654), 0);
    check("midrst.ov", 160'(out_valid), 160'(1'b0));
    check("midrst.pay", 160'(pay_out), 160'(0));
    step(1, 0, 0, '0, '0, 0);
    check("midrst.ready", 160'(in_ready), 160'(1'b1));

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
           CTL_W'($urandom), rnd_pay(), $urandom_range(0, 9) < 7);
    end

    // Saturation: stall for longer than the counter range.
    step(0, 0, 0, '0, '0, 0);
    step(1, 0, 1, 13'h0F0F, mk_pay(32'h400, 13'h0F0F), 1);
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    m_stall = (m_stall + 70000 > 65535) ? 65535 : m_stall + 70000;
    check("sat.value", 160'(stall_cnt), 160'(16'hFFFF));
    for (int k = 0; k < 3; k++) step(1, 0, 0, '0, '0, 0);
    check("sat.stays", 160'(stall_cnt), 160'(16'hFFFF));
    check("sat.held", 160'(ctl_out), 160'(13'h0F0F));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/s_id_ex_pipe.md
S_ID_EX_PIPE -- requirements
Module: s_id_ex_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of each datapath word (npc, read data 1, read data 2, sign-extended immediate).
REQ-002 SHALL provide parameter REG_W, default 5, width of each register-number field (rt, rd).
REQ-003 SHALL provide parameter CTL_W, default 13, width of the packed control bundle {wb[1:0], m[2:0], ex[7:0]}.
REQ-004 SHALL derive localparam PAY_W = 4*DATA_W + 2*REG_W, packed {npc, rdata1, rdata2, sext, rt, rd}, MSB first.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 flush  input  1  squash every held instruction; bubble insertion.
REQ-008 in_valid  input  1  ID stage presents an instruction.
REQ-009 in_ready  output  1  stage accepts; transfer when in_valid && in_ready.
REQ-010 ctl_in  input  CTL_W  ID control bundle.
REQ-011 pay_in  input  PAY_W  ID payload.
REQ-012 out_valid  output  1  EX stage holds a valid instruction.
REQ-013 out_ready  input  1  EX consumes; transfer when out_valid && out_ready.
REQ-014 ctl_out  output  CTL_W  registered control; all-zero whenever out_valid=0.
REQ-015 pay_out  output  PAY_W  registered payload.
REQ-016 stall_cnt  output  16  saturating count of cycles with out_valid && !out_ready.

Function
REQ-017 SHALL hold a main entry (valid, ctl, pay); ctl_out/pay_out/out_valid are driven directly from flops, never from inputs.
REQ-018 SHALL have latency one cycle: an instruction accepted on edge N appears at the outputs after edge N when the main entry is empty or drains on edge N.
REQ-019 State EMPTY (main invalid): accept -> FULL; otherwise stay.
REQ-020 State FULL: out_ready && accept -> FULL with new data; out_ready && !accept -> EMPTY; !out_ready -> hold ctl_out, pay_out, out_valid unchanged (no input may corrupt held data).
REQ-021 SHALL keep pay_out unchanged when an entry is invalidated; only valid and ctl clear.
REQ-022 flush SHALL have priority over every other event: on a flush edge all entries become invalid, ctl_out=0, input transfer on that edge is discarded, stall_cnt unaffected except by REQ-023.
REQ-023 stall_cnt SHALL increment by 1 on each edge where out_valid && !out_ready && !flush, saturate at 16'hFFFF, never wrap.
REQ-024 Simultaneous accept and drain in FULL SHALL lose no instruction and insert no bubble (full throughput, one per cycle).

Reset
REQ-025 On a rising clk edge with rst_n=0: out_valid=0, ctl_out=0, pay_out=0, stall_cnt=0, skid entry invalid; reset overrides flush and handshakes.
REQ-026 Reset asserted mid-transfer SHALL discard both the held and the incoming instruction; in_ready is 1 from the first edge after rst_n returns high.

Configuration
REQ-027 Macro S_ID_EX_SKID_EN SHALL select the ready path.
REQ-028 Without S_ID_EX_SKID_EN: in_ready = out_ready || !out_valid (combinational); states EMPTY/FULL only.
REQ-029 With S_ID_EX_SKID_EN: add one skid entry and state SKID; in_ready = !skid_valid, driven from a flop; FULL && !out_ready && accept -> SKID (input captured in skid); SKID && out_ready -> FULL with skid moved to main; flush or reset empties both; ordering strictly FIFO.

Verification
REQ-030 Reset: hold rst_n=0 two cycles with in_valid=1, flush=0 -> out_valid=0, ctl_out=0, pay_out=0, stall_cnt=0.
REQ-031 Streaming: out_ready=1, send ctl 13'h1ABC, 13'h0123, 13'h1FFF on consecutive cycles -> same values on ctl_out on following consecutive cycles, out_valid continuously 1.
REQ-032 Backpressure: load npc=32'h0000_0040, drop out_ready 5 cycles -> pay_out stable, stall_cnt=5; raise out_ready -> drains, next instruction follows without loss.
REQ-033 Flush: FULL with ctl 13'h1FFF, assert flush with in_valid=1 -> next cycle out_valid=0, ctl_out=0, pay_out unchanged, incoming instruction discarded.
REQ-034 Saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF, stays there.
REQ-035 Skid (macro defined): out_ready=0 while FULL, in_valid=1 with 13'h0AAA -> in_ready=0 next cycle; out_ready=1 -> original then 13'h0AAA delivered in order, in_ready returns to 1.
